// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
// Module      : div32_seq
// Description : Multi-cycle 32-bit restoring divider (signed/unsigned).
//               One quotient bit per clock; quotient -> LO, remainder -> HI.
// Revision    : 1.0  initial release
// ============================================================================
module div32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_rem;      // partial remainder; always < |b| so 32 bits hold it
    logic [31:0] r_dvd;      // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] r_bmag;
    logic [31:0] r_a;        // raw dividend, returned as remainder on divide-by-zero
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic        r_dbz;

    logic [31:0] w_amag;
    logic [31:0] w_bmag;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_qmag;
    logic [31:0] w_rmag;
    logic        w_bz;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    // Operand magnitudes and one shift-and-subtract step, plus final sign fix-up
    always_comb begin
        w_amag  = (sign && a[31]) ? (32'd0 - a) : a;
        w_bmag  = (sign && b[31]) ? (32'd0 - b) : b;
        // 33-bit shifted partial remainder: {rem, next dividend bit}
        w_shift = {r_rem, r_dvd[31]};
        w_ge    = (w_shift >= {1'b0, r_bmag});
        // When the trial succeeds the difference is below |b|, so 32 bits suffice
        w_diff  = w_shift[31:0] - r_bmag;
        w_qmag  = {r_dvd[30:0], w_ge};
        w_rmag  = w_ge ? w_diff : w_shift[31:0];
        w_bz    = (r_bmag == 32'd0);
        // Divide-by-zero bypasses sign correction: all-ones quotient, raw dividend
        w_q_fin = (r_neg_q && !w_bz) ? (32'd0 - w_qmag) : w_qmag;
        w_r_fin = w_bz ? r_a : (r_neg_r ? (32'd0 - w_rmag) : w_rmag);
    end

    // Control FSM and datapath registers; results load on the final RUN edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_count <= 5'd0;
            r_rem   <= 32'd0;
            r_dvd   <= 32'd0;
            r_bmag  <= 32'd0;
            r_a     <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q     <= 32'd0;
            r_r     <= 32'd0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_dvd   <= w_amag;
                        r_bmag  <= w_bmag;
                        r_a     <= a;
                        r_neg_q <= sign & (a[31] ^ b[31]);
                        r_neg_r <= sign & a[31];
                        r_rem   <= 32'd0;
                        r_count <= 5'd0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_rem   <= w_rmag;
                    r_dvd   <= w_qmag;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_q     <= w_q_fin;
                        r_r     <= w_r_fin;
                        r_dbz   <= w_bz;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign dbz  = r_dbz;
    assign busy = (r_state == c_ST_RUN);
    assign done = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div32_seq
// Description : Directed self-checking bench for div32_seq.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div32_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dbz;

    int total = 0;
    int bad   = 0;

    div32_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-edge start pulse; returns just after the accepting edge
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        a = ta; b = tb_v; sign = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sign = ~ts;  // scramble after the edge
    endtask

    // Starting just after the accepting edge, count cycles until done
    // (first cycle after the start edge is cycle 1) and count busy cycles
    task automatic wait_done(output int k, output int nbusy);
        k = 0; nbusy = 0;
        for (int i = 1; i <= 45; i++) begin
            if (done) begin k = i; break; end
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({q, r, dbz, busy, done} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state got q=%h r=%h dbz=%b busy=%b done=%b expected all zero", q, r, dbz, busy, done);
        end
    endtask

    task automatic check_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                            input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        int k, nb;
        issue(ta, tb_v, ts);
        wait_done(k, nb);
        total++;
        if (k !== 33 || nb !== 32) begin
            bad++;
            $display("FAIL %s_latency got done_cycle=%0d busy_cycles=%0d expected 33/32", nm, k, nb);
        end
        total++;
        if (q !== eq || r !== er || dbz !== edbz) begin
            bad++;
            $display("FAIL %s_result got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b", nm, q, r, dbz, eq, er, edbz);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== eq) begin
            bad++;
            $display("FAIL %s_after got done=%b busy=%b q=%h expected 0/0/%h", nm, done, busy, q, eq);
        end
    endtask

    task automatic test_unsigned;
        check_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        check_op("uffffffff_10", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);
    endtask

    task automatic test_signed;
        check_op("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        check_op("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);
        check_op("sm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0);
    endtask

    task automatic test_dbz;
        check_op("dbz_pos", 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        check_op("dbz_neg", 32'hFFFF_FF9C, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
        check_op("dbz_clear", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0);
    endtask

    task automatic test_extremes;
        check_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        check_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check_op("u_8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_back_to_back;
        int k, nb;
        issue(32'd100, 32'd7, 1'b0);
        // cycle 1 now; advance to RUN cycle 5 and pulse a start that must be ignored
        repeat (4) @(posedge clk);
        #1;
        a = 32'd9; b = 32'd3; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        for (int i = 6; i <= 45; i++) begin
            if (done) begin k = i; break; end
            @(posedge clk); #1;
        end
        total++;
        if (k !== 33 || q !== 32'd14 || r !== 32'd2) begin
            bad++;
            $display("FAIL busy_start_ignored got cycle=%0d q=%h r=%h expected 33 q=0000000e r=00000002", k, q, r);
        end
        // start held during DONE: the edge ending DONE must ignore it
        a = 32'd9; b = 32'd3; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL done_edge_start got busy=%b done=%b expected 0/0", busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL e34_accept got busy=%b expected 1", busy);
        end
        wait_done(k, nb);
        total++;
        if (k !== 33 || q !== 32'd3 || r !== 32'd0) begin
            bad++;
            $display("FAIL e34_result got cycle=%0d q=%h r=%h expected 33 q=00000003 r=00000000", k, q, r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        int k, nb, seen;
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 32'd0 || r !== 32'd0 || dbz !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got busy=%b done=%b q=%h r=%h dbz=%b expected all zero", busy, done, q, r, dbz);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL mid_reset_quiet got active_cycles=%0d expected 0", seen);
        end
        issue(32'd1000, 32'd33, 1'b0);
        wait_done(k, nb);
        total++;
        if (k !== 33 || q !== 32'd30 || r !== 32'd10) begin
            bad++;
            $display("FAIL post_reset_op got cycle=%0d q=%h r=%h expected 33 q=0000001e r=0000000a", k, q, r);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_dbz;
        test_extremes;
        test_back_to_back;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
